fsm_state_monitor: RTL and testbench
====================================

# fsm_state_monitor

Downstream observer for the FSM blocks under regression, such as the 7-input FSM `main` with its 4-bit state output `y`. It samples the FSM state code each valid cycle and tracks activity per state: visits, transitions, dwell time, illegal codes and stalls. Statistics are readable through a query port, so regression benches and on-chip debug logic can check FSM coverage without parsing per-cycle `$display` traces.

## Interface
Parameters:
- `W`, 4: width of the observed state code.
- `NUM_STATES`, 8: codes `0..NUM_STATES-1` are legal. Range 2..2^W.
- `CNT_W`, 16: width of all counters. All counters saturate at 2^CNT_W-1.
- `STALL_LIMIT`, 64: dwell length at which `stall` is raised. Range 2..2^CNT_W-1.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-low; clock `clock`.
- `state_in`  in  W  FSM state code, driven from the FSM output `y`.
- `state_valid`  in  1  `state_in` is sampled on this edge. Drive low while the FSM is in reset.
- `clear`  in  1  synchronous statistics clear.
- `query_sel`  in  W  state index for `visit_count`.
- `visit_count`  out  CNT_W  visits to state `query_sel`. Combinational read of the register array. Reads 0 when `query_sel >= NUM_STATES`.
- `trans_count`  out  CNT_W  number of state changes observed.
- `dwell`  out  CNT_W  consecutive valid samples of the current state, counting the current sample.
- `max_dwell`  out  CNT_W  largest `dwell` seen since reset or clear.
- `cur_state`  out  W  last sampled legal state.
- `changed`  out  1  one-cycle pulse: the last sample differed from the previous one.
- `illegal`  out  1  sticky: an out-of-range code was sampled.
- `stall`  out  1  sticky: `dwell` reached `STALL_LIMIT`.

## Operation
- Monitor FSM states:
  - IDLE: no sample taken yet.
  - TRACK: collecting statistics.
  - HALT: illegal code seen; all statistics frozen.
- Reset (`reset`=0) and `clear`=1 have the same effect. All outputs and the visit array go to 0, `cur_state` goes to 0, and the monitor FSM goes to IDLE. Reset has priority over `clear`; `clear` has priority over a sample in the same cycle.
- A cycle with `state_valid`=0 changes nothing, except that `changed` drops to 0.
- Legal sample in IDLE:
  - `cur_state`<=`state_in`, `visit[state_in]`<=1, `dwell`<=1.
  - `max_dwell`<=1 and `trans_count` stays 0.
  - `changed`=0. Go to TRACK.
- Legal sample in TRACK with `state_in != cur_state`:
  - `trans_count`++ and `visit[state_in]`++, both saturating.
  - `dwell`<=1, `changed`<=1, `cur_state`<=`state_in`.
- Legal sample in TRACK with `state_in == cur_state`:
  - `dwell`++ (saturating), `changed`<=0.
- `max_dwell` <= max(`max_dwell`, next `dwell`) on every legal sample.
- `stall` is set on the edge where next `dwell` equals `STALL_LIMIT`. It stays set until reset or clear, and tracking continues.
- Illegal sample (`state_in >= NUM_STATES`) in IDLE or TRACK:
  - `illegal`<=1 and go to HALT.
  - No counter, `cur_state` or `changed` update from that sample.
- HALT ignores all samples. It leaves only by reset or clear.

## Timing
- Every output except `visit_count` is registered and reflects samples up to and including the previous edge.
- Latency from a sample to `changed`, `trans_count`, `dwell`, `stall` and `illegal` is 1 cycle.
- `visit_count` follows `query_sel` combinationally in the same cycle and reflects the array as of the last edge.
- `changed` is high for exactly one cycle per transition. Back-to-back transitions keep it high on consecutive cycles.
- Saturated counters hold at all-ones and never wrap. `dwell` can saturate without a state change, and `max_dwell` then saturates too.
- Reset or clear in mid-run takes effect on the next edge. The sample in that cycle is discarded.
- After leaving reset, the first valid sample is treated as the IDLE entry and is never counted as a transition.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then 1. All outputs read 0. A valid sample of 5 then gives `cur_state`=5, `visit_count`(sel 5)=1, `trans_count`=0, `changed`=0.
- Sequence: samples 0,1,1,2,0. Result: `trans_count`=3, visits 0/1/2 = 2/1/1, `dwell`=1, `max_dwell`=2. `changed` pattern is 0,1,0,1,1.
- Stall: constant state 3 for 64 valid samples with `STALL_LIMIT`=64. `stall` rises the cycle after the 64th sample with `dwell`=64. Bubbles with `state_valid`=0 inserted between samples do not reset `dwell`.
- Illegal: `NUM_STATES`=7, sample 2 then 7. `illegal`=1 the next cycle. Further samples 0,1 leave `trans_count`=0 and `cur_state`=2. `clear` returns the monitor to IDLE with all outputs 0.
- Saturation: `CNT_W`=4, alternate states 1,2 for 20 samples. `trans_count`=15, visits for 1 and 2 = 10 and 10, no wrap.
- Priority: `clear`=1 together with a valid sample of 4 leaves all outputs 0. `reset`=0 together with `clear`=1 behaves as reset.

Source files
------------

// File: rtl/fsm_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_state_monitor
//  Description : Passive observer for an FSM state output. Tracks per-state
//                visit counts, transitions, dwell time, illegal codes and
//                stalls; statistics are readable through a query port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_state_monitor #(
    parameter int W           = 4,
    parameter int NUM_STATES  = 8,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     state_in,
    input  logic             state_valid,
    input  logic             clear,
    input  logic [W-1:0]     query_sel,
    output logic [CNT_W-1:0] visit_count,
    output logic [CNT_W-1:0] trans_count,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] max_dwell,
    output logic [W-1:0]     cur_state,
    output logic             changed,
    output logic             illegal,
    output logic             stall
);

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_TRACK = 2'd1,
        MON_HALT  = 2'd2
    } mon_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX        = '1;
    localparam logic [CNT_W-1:0] STALL_AT       = CNT_W'(STALL_LIMIT);
    localparam logic [W:0]       NUM_STATES_EXT = (W+1)'(NUM_STATES);

    mon_state_t       mon_q, mon_d;
    logic [W-1:0]     cur_state_q, cur_state_d;
    logic [CNT_W-1:0] trans_q, trans_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] max_dwell_q, max_dwell_d;
    logic             changed_q, changed_d;
    logic             illegal_q, illegal_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] visit_q [NUM_STATES];
    logic [CNT_W-1:0] visit_d [NUM_STATES];
    logic             visit_load;
    logic             visit_bump;
    logic             state_legal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign state_legal = ({1'b0, state_in} < NUM_STATES_EXT);

    // Next-state computation for the monitor FSM and every statistic.
    always_comb begin
        mon_d       = mon_q;
        cur_state_d = cur_state_q;
        trans_d     = trans_q;
        dwell_d     = dwell_q;
        max_dwell_d = max_dwell_q;
        changed_d   = 1'b0;
        illegal_d   = illegal_q;
        stall_d     = stall_q;
        visit_d     = visit_q;
        visit_load  = 1'b0;
        visit_bump  = 1'b0;

        if (clear) begin
            mon_d       = MON_IDLE;
            cur_state_d = '0;
            trans_d     = '0;
            dwell_d     = '0;
            max_dwell_d = '0;
            illegal_d   = 1'b0;
            stall_d     = 1'b0;
        end else if (state_valid && (mon_q != MON_HALT)) begin
            if (!state_legal) begin
                // Freeze everything; only reset or clear leaves HALT.
                illegal_d = 1'b1;
                mon_d     = MON_HALT;
            end else begin
                if (mon_q == MON_IDLE) begin
                    // First sample is an entry, never a transition.
                    cur_state_d = state_in;
                    dwell_d     = CNT_W'(1);
                    visit_load  = 1'b1;
                    mon_d       = MON_TRACK;
                end else if (state_in != cur_state_q) begin
                    cur_state_d = state_in;
                    trans_d     = sat_inc(trans_q);
                    dwell_d     = CNT_W'(1);
                    changed_d   = 1'b1;
                    visit_bump  = 1'b1;
                end else begin
                    dwell_d = sat_inc(dwell_q);
                end
                if (dwell_d > max_dwell_q) begin
                    max_dwell_d = dwell_d;
                end
                if (dwell_d == STALL_AT) begin
                    stall_d = 1'b1;
                end
            end
        end

        for (int i = 0; i < NUM_STATES; i++) begin
            if (clear) begin
                visit_d[i] = '0;
            end else if (state_in == W'(i)) begin
                if (visit_load) begin
                    visit_d[i] = CNT_W'(1);
                end else if (visit_bump) begin
                    visit_d[i] = sat_inc(visit_q[i]);
                end
            end
        end
    end

    // Register all state; reset wins over everything else.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mon_q       <= MON_IDLE;
            cur_state_q <= '0;
            trans_q     <= '0;
            dwell_q     <= '0;
            max_dwell_q <= '0;
            changed_q   <= 1'b0;
            illegal_q   <= 1'b0;
            stall_q     <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                visit_q[i] <= '0;
            end
        end else begin
            mon_q       <= mon_d;
            cur_state_q <= cur_state_d;
            trans_q     <= trans_d;
            dwell_q     <= dwell_d;
            max_dwell_q <= max_dwell_d;
            changed_q   <= changed_d;
            illegal_q   <= illegal_d;
            stall_q     <= stall_d;
            visit_q     <= visit_d;
        end
    end

    // Query mux; indices outside the legal range read as zero.
    always_comb begin
        visit_count = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (query_sel == W'(i)) begin
                visit_count = visit_q[i];
            end
        end
    end

    assign trans_count = trans_q;
    assign dwell       = dwell_q;
    assign max_dwell   = max_dwell_q;
    assign cur_state   = cur_state_q;
    assign changed     = changed_q;
    assign illegal     = illegal_q;
    assign stall       = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_state_monitor
//  Description : Directed bench for fsm_state_monitor. Two instances with
//                different parameters share stimulus; a statistics model is
//                compared every cycle, plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_state_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] state_in;
    logic       state_valid;
    logic       clear;
    logic [3:0] query_sel;

    logic [15:0] a_vc, a_tc, a_dw, a_md;
    logic [3:0]  a_cs;
    logic        a_ch, a_il, a_st;
    logic [3:0]  b_vc, b_tc, b_dw, b_md;
    logic [3:0]  b_cs;
    logic        b_ch, b_il, b_st;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    fsm_state_monitor #(.W(4), .NUM_STATES(7), .CNT_W(16), .STALL_LIMIT(64)) dut_a (
        .clock(clock), .reset(reset), .state_in(state_in), .state_valid(state_valid),
        .clear(clear), .query_sel(query_sel), .visit_count(a_vc), .trans_count(a_tc),
        .dwell(a_dw), .max_dwell(a_md), .cur_state(a_cs), .changed(a_ch),
        .illegal(a_il), .stall(a_st));

    fsm_state_monitor #(.W(4), .NUM_STATES(8), .CNT_W(4), .STALL_LIMIT(5)) dut_b (
        .clock(clock), .reset(reset), .state_in(state_in), .state_valid(state_valid),
        .clear(clear), .query_sel(query_sel), .visit_count(b_vc), .trans_count(b_tc),
        .dwell(b_dw), .max_dwell(b_md), .cur_state(b_cs), .changed(b_ch),
        .illegal(b_il), .stall(b_st));

    // Model configuration per unit: legal state count, counter ceiling, stall limit.
    int ns   [2] = '{7, 8};
    int cmax [2] = '{65535, 15};
    int slim [2] = '{64, 5};

    int m_vis [2][16];
    int m_tr [2], m_dw [2], m_md [2], m_cur [2];
    bit m_chg [2], m_ill [2], m_stl [2], m_started [2], m_halt [2];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input int m);
        return (v < m) ? v + 1 : m;
    endfunction

    task automatic model_wipe(input int u);
        for (int s = 0; s < 16; s++) m_vis[u][s] = 0;
        m_tr[u] = 0; m_dw[u] = 0; m_md[u] = 0; m_cur[u] = 0;
        m_chg[u] = 0; m_ill[u] = 0; m_stl[u] = 0;
        m_started[u] = 0; m_halt[u] = 0;
    endtask

    // Statistics as the rules define them, applied to one sampled edge.
    task automatic model_step(input int u);
        int s;
        s = int'(state_in);
        if (!reset || clear) begin
            model_wipe(u);
        end else begin
            m_chg[u] = 0;
            if (state_valid && !m_halt[u]) begin
                if (s >= ns[u]) begin
                    m_ill[u]  = 1;
                    m_halt[u] = 1;
                end else begin
                    if (!m_started[u]) begin
                        m_started[u] = 1;
                        m_vis[u][s]  = 1;
                        m_dw[u]      = 1;
                    end else if (s != m_cur[u]) begin
                        m_tr[u]     = bump(m_tr[u], cmax[u]);
                        m_vis[u][s] = bump(m_vis[u][s], cmax[u]);
                        m_dw[u]     = 1;
                        m_chg[u]    = 1;
                    end else begin
                        m_dw[u] = bump(m_dw[u], cmax[u]);
                    end
                    m_cur[u] = s;
                    if (m_dw[u] > m_md[u]) m_md[u] = m_dw[u];
                    if (m_dw[u] == slim[u]) m_stl[u] = 1;
                end
            end
        end
    endtask

    // Advance the model on the same edge the DUTs sample.
    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) model_step(u);
    end

    task automatic cmp_unit(input int u, input int vc, input int tc, input int dw,
                            input int md, input int cs, input int ch, input int il,
                            input int st);
        int exp_vc;
        exp_vc = (int'(query_sel) < ns[u]) ? m_vis[u][query_sel] : 0;
        chk($sformatf("u%0d visit_count[%0d]", u, query_sel), vc, exp_vc);
        chk($sformatf("u%0d trans_count", u), tc, m_tr[u]);
        chk($sformatf("u%0d dwell", u), dw, m_dw[u]);
        chk($sformatf("u%0d max_dwell", u), md, m_md[u]);
        chk($sformatf("u%0d cur_state", u), cs, m_cur[u]);
        chk($sformatf("u%0d changed", u), ch, int'(m_chg[u]));
        chk($sformatf("u%0d illegal", u), il, int'(m_ill[u]));
        chk($sformatf("u%0d stall", u), st, int'(m_stl[u]));
    endtask

    // Per-cycle comparison, mid-cycle while inputs are stable.
    always @(negedge clock) begin
        if (check_en) begin
            cmp_unit(0, a_vc, a_tc, a_dw, a_md, a_cs, a_ch, a_il, a_st);
            cmp_unit(1, b_vc, b_tc, b_dw, b_md, b_cs, b_ch, b_il, b_st);
        end
    end

    // Drive one cycle of inputs; returns shortly after the sampling edge.
    task automatic step(input logic v, input logic [3:0] s, input logic c, input logic r);
        state_valid = v;
        state_in    = s;
        clear       = c;
        reset       = r;
        @(posedge clock);
        #3;
    endtask

    // Read visit counts for one index in an idle cycle.
    task automatic qchk(input logic [3:0] sel, input int exp_a, input int exp_b, input string name);
        state_valid = 1'b0;
        clear       = 1'b0;
        reset       = 1'b1;
        query_sel   = sel;
        #1;
        chk({name, " a"}, a_vc, exp_a);
        chk({name, " b"}, b_vc, exp_b);
        @(posedge clock);
        #3;
    endtask

    logic [3:0] seq_s [5] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd0};
    int         seq_c [5] = '{0, 1, 0, 1, 1};

    initial begin
        reset = 1'b0; clear = 1'b0; state_valid = 1'b0; state_in = '0; query_sel = '0;

        // Reset held three cycles, then released.
        repeat (3) step(1'b0, 4'd0, 1'b0, 1'b0);
        check_en = 1'b1;
        chk("reset trans_count", a_tc, 0);
        chk("reset dwell", a_dw, 0);
        chk("reset cur_state", a_cs, 0);
        chk("reset flags", {a_ch, a_il, a_st}, 0);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        chk("first cur_state", a_cs, 5);
        chk("first trans_count", a_tc, 0);
        chk("first changed", a_ch, 0);
        qchk(4'd5, 1, 1, "first visit5");

        // Sequence 0,1,1,2,0 after a clear.
        step(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq_s[i], 1'b0, 1'b1);
            chk($sformatf("seq changed[%0d]", i), a_ch, seq_c[i]);
        end
        chk("seq trans_count", a_tc, 3);
        chk("seq dwell", a_dw, 1);
        chk("seq max_dwell", a_md, 2);
        qchk(4'd0, 2, 2, "seq visit0");
        qchk(4'd1, 1, 1, "seq visit1");
        qchk(4'd2, 1, 1, "seq visit2");
        qchk(4'd7, 0, 0, "seq visit7");
        qchk(4'd15, 0, 0, "seq visit15");

        // Stall: 64 samples of state 3 with bubbles in between.
        step(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            query_sel = 4'(i);
            step(1'b1, 4'd3, 1'b0, 1'b1);
            if (i == 62) chk("stall before limit", a_st, 0);
            if (i % 8 == 2) step(1'b0, 4'd1, 1'b0, 1'b1);
        end
        chk("stall at limit", a_st, 1);
        chk("stall dwell", a_dw, 64);
        chk("stall max_dwell", a_md, 64);
        chk("stall b dwell saturated", b_dw, 15);
        chk("stall b max_dwell saturated", b_md, 15);
        chk("stall b flag", b_st, 1);

        // Illegal code 7 on the 7-state unit.
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b1, 4'd2, 1'b0, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b1);
        chk("illegal flag", a_il, 1);
        step(1'b1, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd1, 1'b0, 1'b1);
        chk("illegal trans frozen", a_tc, 0);
        chk("illegal cur_state frozen", a_cs, 2);
        chk("illegal b trans", b_tc, 3);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("illegal cleared", a_il, 0);
        chk("illegal clear cur_state", a_cs, 0);
        chk("illegal clear dwell", a_dw, 0);

        // Saturation: alternate 1,2 for 20 samples.
        for (int i = 0; i < 20; i++) begin
            query_sel = 4'(i % 3);
            step(1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, 1'b0, 1'b1);
        end
        chk("sat b trans_count", b_tc, 15);
        chk("sat a trans_count", a_tc, 19);
        qchk(4'd1, 10, 10, "sat visit1");
        qchk(4'd2, 10, 10, "sat visit2");

        // Priority: clear over sample, reset over clear.
        step(1'b1, 4'd4, 1'b1, 1'b1);
        chk("clear+sample trans", a_tc, 0);
        chk("clear+sample dwell", a_dw, 0);
        chk("clear+sample cur_state", a_cs, 0);
        qchk(4'd4, 0, 0, "clear+sample visit4");
        step(1'b1, 4'd3, 1'b0, 1'b1);
        step(1'b1, 4'd6, 1'b1, 1'b0);
        chk("reset+clear dwell", a_dw, 0);
        chk("reset+clear cur_state", a_cs, 0);
        step(1'b1, 4'd2, 1'b0, 1'b1);
        chk("post reset cur_state", a_cs, 2);
        chk("post reset changed", a_ch, 0);
        chk("post reset trans", a_tc, 0);
        step(1'b0, 4'd0, 1'b0, 1'b1);

        @(negedge clock);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
